// File: rtl/sap_1_controller_sequencer.sv
// SAP-1 controller-sequencer: six-state ring counter (T1..T6) decoding the IR opcode into the 12-bit control word.
// Latency: CON/T/HltN are registered together, valid clk-to-q after each rising edge; no backpressure, HLT freezes everything until ClrN.
module sap_1_controller_sequencer (
    input  logic        ClkN,
    input  logic        ClrN,
    input  logic [7:4]  opcode,
    output logic [11:0] CON,
    output logic [6:1]  T,
    output logic        HltN
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4,
        S_T5   = 3'd5,
        S_T6   = 3'd6
    } state_t;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // {Cp, Ep, LMbar, CEbar, LIbar, EIbar, LAbar, Ea, Su, Eu, LBbar, LObar}
    localparam logic [11:0] CW_NOP     = 12'h3E3;
    localparam logic [11:0] CW_FETCH1  = 12'h5E3;
    localparam logic [11:0] CW_FETCH2  = 12'hBE3;
    localparam logic [11:0] CW_FETCH3  = 12'h263;
    localparam logic [11:0] CW_IR2MAR  = 12'h1A3;
    localparam logic [11:0] CW_RAM2A   = 12'h2C3;
    localparam logic [11:0] CW_RAM2B   = 12'h2E1;
    localparam logic [11:0] CW_ADD2A   = 12'h3C7;
    localparam logic [11:0] CW_SUB2A   = 12'h3CF;
    localparam logic [11:0] CW_A2OUT   = 12'h3F2;

    state_t      state_q, state_d;
    logic [6:1]  t_q, t_d;
    logic [11:0] con_q, con_d;
    logic        hlt_n_q, hlt_n_d;

    function automatic logic [6:1] state_onehot(input state_t s);
        logic [6:1] oh;
        oh = 6'b000000;
        case (s)
            S_T1:    oh = 6'b000001;
            S_T2:    oh = 6'b000010;
            S_T3:    oh = 6'b000100;
            S_T4:    oh = 6'b001000;
            S_T5:    oh = 6'b010000;
            S_T6:    oh = 6'b100000;
            default: oh = 6'b000000;
        endcase
        return oh;
    endfunction

    function automatic logic [11:0] decode(input state_t s, input logic [3:0] op);
        logic [11:0] cw;
        cw = CW_NOP;
        case (s)
            S_T1: cw = CW_FETCH1;
            S_T2: cw = CW_FETCH2;
            S_T3: cw = CW_FETCH3;
            S_T4: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB: cw = CW_IR2MAR;
                    OP_OUT:                 cw = CW_A2OUT;
                    default:                cw = CW_NOP;
                endcase
            end
            S_T5: begin
                case (op)
                    OP_LDA:         cw = CW_RAM2A;
                    OP_ADD, OP_SUB: cw = CW_RAM2B;
                    default:        cw = CW_NOP;
                endcase
            end
            S_T6: begin
                case (op)
                    OP_ADD:  cw = CW_ADD2A;
                    OP_SUB:  cw = CW_SUB2A;
                    default: cw = CW_NOP;
                endcase
            end
            default: cw = CW_NOP;
        endcase
        return cw;
    endfunction

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        con_d   = con_q;
        hlt_n_d = hlt_n_q;
        // Once halted every register holds; only the async clear leaves this.
        if (hlt_n_q) begin
            case (state_q)
                S_IDLE:  state_d = S_T1;
                S_T1:    state_d = S_T2;
                S_T2:    state_d = S_T3;
                S_T3:    state_d = S_T4;
                S_T4:    state_d = S_T5;
                S_T5:    state_d = S_T6;
                S_T6:    state_d = S_T1;
                default: state_d = S_IDLE;
            endcase
            t_d   = state_onehot(state_d);
            con_d = decode(state_d, opcode);
            if (state_d == S_T4 && opcode == OP_HLT) begin
                hlt_n_d = 1'b0;
            end
        end
    end

    always_ff @(posedge ClkN or negedge ClrN) begin
        if (!ClrN) begin
            state_q <= S_IDLE;
            t_q     <= 6'b000000;
            con_q   <= CW_NOP;
            hlt_n_q <= 1'b1;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            con_q   <= con_d;
            hlt_n_q <= hlt_n_d;
        end
    end

    assign CON  = con_q;
    assign T    = t_q;
    assign HltN = hlt_n_q;

endmodule

// File: tb/tb_sap_1_controller_sequencer.sv
// Directed bench for the SAP-1 controller-sequencer: fetch/execute words per opcode, halt, async clear.
module tb_sap_1_controller_sequencer;

    logic        ClkN;
    logic        ClrN;
    logic [7:4]  opcode;
    logic [11:0] CON;
    logic [6:1]  T;
    logic        HltN;

    int checks = 0;
    int errors = 0;

    sap_1_controller_sequencer dut (
        .ClkN   (ClkN),
        .ClrN   (ClrN),
        .opcode (opcode),
        .CON    (CON),
        .T      (T),
        .HltN   (HltN)
    );

    initial ClkN = 1'b0;
    always #5 ClkN = ~ClkN;

    always @(negedge ClkN) begin
        checks++;
        if (!$onehot0(T)) begin
            errors++;
            $display("FAIL t_onehot0 T=%b required one-hot or zero", T);
        end
    end

    task automatic step();
        @(posedge ClkN);
        #1;
    endtask

    task automatic do_reset();
        @(negedge ClkN);
        ClrN = 1'b0;
        @(negedge ClkN);
        ClrN = 1'b1;
    endtask

    // Expected T4..T6 words per opcode, k = 1..3.
    function automatic logic [11:0] ref_exec(input logic [3:0] op, input int k);
        logic [35:0] row;
        case (op)
            4'b0000: row = {12'h1A3, 12'h2C3, 12'h3E3};
            4'b0001: row = {12'h1A3, 12'h2E1, 12'h3C7};
            4'b0010: row = {12'h1A3, 12'h2E1, 12'h3CF};
            4'b1110: row = {12'h3F2, 12'h3E3, 12'h3E3};
            default: row = {12'h3E3, 12'h3E3, 12'h3E3};
        endcase
        return row[(3 - k) * 12 +: 12];
    endfunction

    task automatic test_reset();
        logic [11:0] exp [3];
        logic [6:1]  texp;
        exp = '{12'h5E3, 12'hBE3, 12'h263};
        ClrN   = 1'b0;
        opcode = 4'b0000;
        step();
        step();
        checks++; if (T !== 6'b000000) begin errors++; $display("FAIL reset_T got %b want 000000", T); end
        checks++; if (CON !== 12'h3E3) begin errors++; $display("FAIL reset_CON got %h want 3e3", CON); end
        checks++; if (HltN !== 1'b1) begin errors++; $display("FAIL reset_HltN got %b want 1", HltN); end
        @(negedge ClkN);
        ClrN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            texp = 6'(1 << i);
            checks++; if (CON !== exp[i]) begin errors++; $display("FAIL fetch_CON T%0d got %h want %h", i + 1, CON, exp[i]); end
            checks++; if (T !== texp) begin errors++; $display("FAIL fetch_T T%0d got %b want %b", i + 1, T, texp); end
        end
    endtask

    task automatic test_lda_add();
        logic [11:0] exp_lda [7];
        logic [11:0] exp_add [5];
        logic [6:1]  texp;
        exp_lda = '{12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2C3, 12'h3E3, 12'h5E3};
        exp_add = '{12'hBE3, 12'h263, 12'h1A3, 12'h2E1, 12'h3C7};
        opcode = 4'b0000;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step();
            texp = 6'(1 << (i % 6));
            checks++; if (CON !== exp_lda[i]) begin errors++; $display("FAIL lda_CON step%0d got %h want %h", i, CON, exp_lda[i]); end
            checks++; if (T !== texp) begin errors++; $display("FAIL lda_T step%0d got %b want %b", i, T, texp); end
        end
        opcode = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            step();
            texp = 6'(1 << (i + 1));
            checks++; if (CON !== exp_add[i]) begin errors++; $display("FAIL add_CON step%0d got %h want %h", i, CON, exp_add[i]); end
            checks++; if (T !== texp) begin errors++; $display("FAIL add_T step%0d got %b want %b", i, T, texp); end
        end
    endtask

    task automatic test_sub_out_nop();
        logic [3:0]  ops [3];
        logic [11:0] exp [3][3];
        logic [11:0] fetch [3];
        logic [11:0] want;
        ops   = '{4'b0010, 4'b1110, 4'b0101};
        exp   = '{'{12'h1A3, 12'h2E1, 12'h3CF},
                  '{12'h3F2, 12'h3E3, 12'h3E3},
                  '{12'h3E3, 12'h3E3, 12'h3E3}};
        fetch = '{12'h5E3, 12'hBE3, 12'h263};
        opcode = ops[0];
        do_reset();
        for (int n = 0; n < 3; n++) begin
            opcode = ops[n];
            for (int i = 0; i < 6; i++) begin
                step();
                want = (i < 3) ? fetch[i] : exp[n][i - 3];
                checks++; if (CON !== want) begin errors++; $display("FAIL op%b_CON T%0d got %h want %h", ops[n], i + 1, CON, want); end
                checks++; if (HltN !== 1'b1) begin errors++; $display("FAIL op%b_HltN T%0d got %b want 1", ops[n], i + 1, HltN); end
            end
        end
    endtask

    task automatic test_halt();
        opcode = 4'b1111;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        checks++; if (HltN !== 1'b0) begin errors++; $display("FAIL halt_HltN got %b want 0", HltN); end
        checks++; if (T !== 6'b001000) begin errors++; $display("FAIL halt_T got %b want 001000", T); end
        checks++; if (CON !== 12'h3E3) begin errors++; $display("FAIL halt_CON got %h want 3e3", CON); end
        for (int i = 0; i < 10; i++) begin
            opcode = (i % 2 == 0) ? 4'b0001 : 4'b1110;
            step();
            checks++;
            if (T !== 6'b001000 || CON !== 12'h3E3 || HltN !== 1'b0) begin
                errors++;
                $display("FAIL halt_hold edge%0d got T=%b CON=%h HltN=%b want 001000 3e3 0", i, T, CON, HltN);
            end
        end
        @(negedge ClkN);
        ClrN = 1'b0;
        #1;
        checks++; if (T !== 6'b000000 || HltN !== 1'b1 || CON !== 12'h3E3) begin
            errors++; $display("FAIL halt_clear got T=%b CON=%h HltN=%b want 000000 3e3 1", T, CON, HltN);
        end
        @(negedge ClkN);
        ClrN = 1'b1;
        // Clear held across the edge that would enter HLT's T4.
        opcode = 4'b1111;
        do_reset();
        for (int i = 0; i < 3; i++) step();
        @(negedge ClkN);
        ClrN = 1'b0;
        step();
        checks++; if (HltN !== 1'b1 || T !== 6'b000000) begin
            errors++; $display("FAIL halt_reset_wins got T=%b HltN=%b want 000000 1", T, HltN);
        end
        @(negedge ClkN);
        ClrN = 1'b1;
        step();
        checks++; if (CON !== 12'h5E3 || HltN !== 1'b1) begin
            errors++; $display("FAIL halt_reset_restart got CON=%h HltN=%b want 5e3 1", CON, HltN);
        end
    endtask

    task automatic test_async_reset();
        opcode = 4'b0001;
        do_reset();
        for (int i = 0; i < 5; i++) step();
        checks++; if (CON !== 12'h2E1) begin errors++; $display("FAIL async_pre_CON got %h want 2e1", CON); end
        #2;
        ClrN = 1'b0;
        #1;
        checks++; if (T !== 6'b000000) begin errors++; $display("FAIL async_T got %b want 000000", T); end
        checks++; if (CON !== 12'h3E3) begin errors++; $display("FAIL async_CON got %h want 3e3", CON); end
        @(negedge ClkN);
        ClrN = 1'b1;
        step();
        checks++; if (CON !== 12'h5E3 || T !== 6'b000001) begin
            errors++; $display("FAIL async_restart got CON=%h T=%b want 5e3 000001", CON, T);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [10];
        logic [11:0] fetch [3];
        logic [11:0] want;
        logic [6:1]  texp;
        logic        hexp;
        int          tidx;
        ops   = '{4'b0000, 4'b0001, 4'b0010, 4'b1110, 4'b0000,
                  4'b0010, 4'b0001, 4'b1110, 4'b0010, 4'b1111};
        fetch = '{12'h5E3, 12'hBE3, 12'h263};
        opcode = ops[0];
        do_reset();
        for (int n = 0; n < 10; n++) begin
            opcode = ops[n];
            for (int s = 1; s <= 6; s++) begin
                step();
                tidx = (ops[n] == 4'b1111 && s > 4) ? 4 : s;
                texp = 6'(1 << (tidx - 1));
                hexp = !(ops[n] == 4'b1111 && s >= 4);
                if (s <= 3)               want = fetch[s - 1];
                else if (ops[n] == 4'b1111) want = 12'h3E3;
                else                      want = ref_exec(ops[n], s - 3);
                checks++;
                if (CON !== want || T !== texp || HltN !== hexp) begin
                    errors++;
                    $display("FAIL b2b instr%0d op%b T%0d got CON=%h T=%b HltN=%b want %h %b %b",
                             n, ops[n], s, CON, T, HltN, want, texp, hexp);
                end
            end
        end
    endtask

    initial begin
        ClrN   = 1'b0;
        opcode = 4'b0000;
        test_reset();
        test_lda_add();
        test_sub_out_nop();
        test_halt();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
